// File: rtl/riscv_mem_slave_pkg.sv
// Shared definitions for the memory slave: register map, wait-config width,
// read FSM encoding and a byte-lane merge helper.
package riscv_mem_slave_pkg;

  localparam int WAIT_W = 4;

  localparam logic [5:0] OFS_MTIME_LO    = 6'h00;
  localparam logic [5:0] OFS_MTIME_HI    = 6'h04;
  localparam logic [5:0] OFS_MTIMECMP_LO = 6'h08;
  localparam logic [5:0] OFS_MTIMECMP_HI = 6'h0C;
  localparam logic [5:0] OFS_WAITCFG     = 6'h10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  // Replace only the lanes selected by be; other lanes keep the old value.
  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/riscv_mem_timer.sv
// 64-bit free-running MTIME with MTIMECMP compare and a registered interrupt.
module riscv_mem_timer
  import riscv_mem_slave_pkg::*;
(
  input  logic        clk,
  input  logic        nreset,
  input  logic        wr_en_i,
  input  logic [1:0]  wr_sel_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic [63:0] mtime_o,
  output logic [63:0] mtimecmp_o,
  output logic        irq_o
);

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        irq_q, irq_d;

  // A write to an MTIME half replaces that half and suppresses the increment.
  always_comb begin
    mtime_d    = mtime_q + 64'd1;
    mtimecmp_d = mtimecmp_q;
    irq_d      = (mtime_q >= mtimecmp_q);
    if (wr_en_i) begin
      case (wr_sel_i)
        2'd0: mtime_d = {mtime_q[63:32], be_merge(mtime_q[31:0], wdata_i, be_i)};
        2'd1: mtime_d = {be_merge(mtime_q[63:32], wdata_i, be_i), mtime_q[31:0]};
        2'd2: mtimecmp_d = {mtimecmp_q[63:32], be_merge(mtimecmp_q[31:0], wdata_i, be_i)};
        default: mtimecmp_d = {be_merge(mtimecmp_q[63:32], wdata_i, be_i), mtimecmp_q[31:0]};
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      irq_q      <= irq_d;
    end
  end

  assign mtime_o    = mtime_q;
  assign mtimecmp_o = mtimecmp_q;
  assign irq_o      = irq_q;

endmodule

// File: rtl/riscv_mem_slave.sv
// Word RAM plus timer/config registers behind a waitrequest-style bus:
// zero-wait writes, reads with a programmable number of wait cycles.
module riscv_mem_slave
  import riscv_mem_slave_pkg::*;
#(
  parameter int                MEM_AW     = 12,
  parameter logic [31:0]       REG_BASE   = 32'hAFFFE000,
  parameter logic [WAIT_W-1:0] RESET_WAIT = 4'd1
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [31:0] address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  input  logic        read,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic        irq
);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [WAIT_W-1:0] waitcfg_q, waitcfg_d;
  logic [31:0]       readdata_q, readdata_d;
  logic [31:0]       ram_rdata_q;
  logic [31:0]       mem [2**MEM_AW];

  logic              wr_accept;
  logic              capture;
  logic              ram_hit;
  logic              reg_hit;
  logic [MEM_AW-1:0] ram_idx;
  logic [31:0]       reg_rdata;
  logic [31:0]       rd_mux;
  logic              timer_wr;
  logic [63:0]       mtime;
  logic [63:0]       mtimecmp;

  assign ram_hit = (address[31:MEM_AW+2] == '0);
  assign reg_hit = (address[31:6] == REG_BASE[31:6]);
  assign ram_idx = address[MEM_AW+1:2];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_accept = 1'b0;
    capture   = 1'b0;
    waitrequest = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (write) begin
          wr_accept   = 1'b1;
          waitrequest = 1'b0;
        end else if (read) begin
          state_d = ST_WAIT;
          cnt_d   = waitcfg_q;
        end
      end
      ST_WAIT: begin
        if (!read) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_ACK;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
        end
      end
      ST_ACK: begin
        waitrequest = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    reg_rdata = 32'h0;
    case (address[5:0])
      OFS_MTIME_LO:    reg_rdata = mtime[31:0];
      OFS_MTIME_HI:    reg_rdata = mtime[63:32];
      OFS_MTIMECMP_LO: reg_rdata = mtimecmp[31:0];
      OFS_MTIMECMP_HI: reg_rdata = mtimecmp[63:32];
      OFS_WAITCFG:     reg_rdata = {{(32-WAIT_W){1'b0}}, waitcfg_q};
      default:         reg_rdata = 32'h0;
    endcase
  end

  always_comb begin
    rd_mux = 32'h0;
    if (ram_hit)      rd_mux = ram_rdata_q;
    else if (reg_hit) rd_mux = reg_rdata;
    readdata_d = capture ? rd_mux : readdata_q;
  end

  always_comb begin
    waitcfg_d = waitcfg_q;
    if (wr_accept && reg_hit && address[5:0] == OFS_WAITCFG && byteenable[0])
      waitcfg_d = writedata[WAIT_W-1:0];
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      waitcfg_q  <= RESET_WAIT;
      readdata_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      waitcfg_q  <= waitcfg_d;
      readdata_q <= readdata_d;
    end
  end

  // RAM is deliberately outside reset; the read port runs every cycle so the
  // word is ready by the time the FSM leaves WAIT.
  always_ff @(posedge clk) begin
    if (wr_accept && ram_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (byteenable[i]) mem[ram_idx][8*i +: 8] <= writedata[8*i +: 8];
      end
    end
    ram_rdata_q <= mem[ram_idx];
  end

  assign timer_wr = wr_accept && reg_hit && (|byteenable) &&
                    (address[5:4] == 2'b00) && (address[1:0] == 2'b00);

  riscv_mem_timer u_timer (
    .clk        (clk),
    .nreset     (nreset),
    .wr_en_i    (timer_wr),
    .wr_sel_i   (address[3:2]),
    .wdata_i    (writedata),
    .be_i       (byteenable),
    .mtime_o    (mtime),
    .mtimecmp_o (mtimecmp),
    .irq_o      (irq)
  );

  assign readdata = readdata_q;

endmodule

// File: tb/tb_riscv_mem_slave.sv
// Scoreboard bench for riscv_mem_slave: expected read data is queued when a
// read is issued and compared when the slave completes it.
module tb_riscv_mem_slave;

  localparam logic [31:0] RB = 32'hAFFFE000;

  logic        clk = 1'b0;
  logic        nreset;
  logic [31:0] address;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        read;
  logic [31:0] readdata;
  logic        waitrequest;
  logic        irq;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cur_w = 1;
  logic [31:0] exp_q[$];

  riscv_mem_slave dut (
    .clk         (clk),
    .nreset      (nreset),
    .address     (address),
    .write       (write),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .read        (read),
    .readdata    (readdata),
    .waitrequest (waitrequest),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    address = a; writedata = d; byteenable = be; write = 1'b1;
    tick();
    write = 1'b0;
    $display("write addr=%08h data=%08h be=%b", a, d, be);
  endtask

  task automatic set_wait(input int w);
    do_write(RB + 32'h10, w, 4'hF);
    cur_w = w;
  endtask

  // lat = edges from the first read cycle until waitrequest low, -1 on timeout
  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output int lat);
    address = a; read = 1'b1; lat = -1;
    for (int n = 1; n <= 64; n++) begin
      tick();
      if (!waitrequest) begin
        lat = n;
        break;
      end
    end
    d = readdata;
    read = 1'b0;
    tick();
    $display("read  addr=%08h data=%08h latency=%0d", a, d, lat);
  endtask

  task automatic test_reset();
    logic [31:0] d, e;
    int lat;
    nreset = 1'b0; write = 1'b0; read = 1'b0; address = '0; writedata = '0; byteenable = '0;
    tick(); tick(); tick();
    n_cmp++; if (waitrequest !== 1'b1) begin n_bad++; $display("FAIL reset_waitreq got=%b want=1", waitrequest); end
    n_cmp++; if (readdata !== 32'h0) begin n_bad++; $display("FAIL reset_readdata got=%08h want=00000000", readdata); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq got=%b want=0", irq); end
    nreset = 1'b1;
    tick();
    exp_q.push_back(32'hFFFFFFFF);
    do_read(RB + 32'h08, d, lat);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL reset_cmp_lo got=%08h want=%08h", d, e); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL reset_latency got=%0d want=3", lat); end
    exp_q.push_back(32'hFFFFFFFF);
    do_read(RB + 32'h0C, d, lat);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL reset_cmp_hi got=%08h want=%08h", d, e); end
    exp_q.push_back(32'h1);
    do_read(RB + 32'h10, d, lat);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL reset_waitcfg got=%08h want=%08h", d, e); end
  endtask

  task automatic test_ram_rw();
    logic [31:0] d, e;
    int lat;
    address = 32'h100; writedata = 32'hDEADBEEF; byteenable = 4'hF; write = 1'b1;
    #1;
    n_cmp++; if (waitrequest !== 1'b0) begin n_bad++; $display("FAIL write_zero_wait got=%b want=0", waitrequest); end
    tick();
    write = 1'b0;
    #1;
    n_cmp++; if (waitrequest !== 1'b1) begin n_bad++; $display("FAIL idle_waitreq got=%b want=1", waitrequest); end
    exp_q.push_back(32'hDEADBEEF);
    do_read(32'h100, d, lat);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL ram_data got=%08h want=%08h", d, e); end
    n_cmp++; if (lat !== cur_w + 2) begin n_bad++; $display("FAIL ram_latency got=%0d want=%0d", lat, cur_w + 2); end
  endtask

  task automatic test_byteenable();
    logic [31:0] d, e;
    int lat;
    do_write(32'h200, 32'hFFFFFFFF, 4'hF);
    do_write(32'h200, 32'h11223344, 4'b0101);
    exp_q.push_back(32'hFF22FF44);
    do_read(32'h200, d, lat);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL be_lanes got=%08h want=%08h", d, e); end
    do_write(32'h200, 32'h00000000, 4'b0000);
    exp_q.push_back(32'hFF22FF44);
    do_read(32'h200, d, lat);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL be_zero_noop got=%08h want=%08h", d, e); end
  endtask

  task automatic test_latency();
    logic [31:0] d, e;
    int lat;
    do_write(32'h0, 32'h0BADF00D, 4'hF);
    set_wait(5);
    exp_q.push_back(32'h0BADF00D);
    do_read(32'h0, d, lat);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL lat5_data got=%08h want=%08h", d, e); end
    n_cmp++; if (lat !== 7) begin n_bad++; $display("FAIL lat5_cycles got=%0d want=7", lat); end
    set_wait(0);
    exp_q.push_back(32'h0BADF00D);
    do_read(32'h0, d, lat);
    e = exp_q.pop_front();
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL lat0_cycles got=%0d want=2", lat); end
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL lat0_data got=%08h want=%08h", d, e); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, e;
    int lat;
    byteenable = 4'hF;
    address = 32'h300; writedata = 32'hA5A5_0001; write = 1'b1;
    tick();
    address = 32'h304; writedata = 32'h5A5A_0002;
    tick();
    write = 1'b0;
    exp_q.push_back(32'hA5A5_0001);
    exp_q.push_back(32'h5A5A_0002);
    do_read(32'h300, d, lat);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL b2b_first got=%08h want=%08h", d, e); end
    do_read(32'h304, d, lat);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL b2b_second got=%08h want=%08h", d, e); end
    // read and write together: the write wins and the read starts afterwards
    address = 32'h308; writedata = 32'hC0FFEE00; write = 1'b1; read = 1'b1;
    #1;
    n_cmp++; if (waitrequest !== 1'b0) begin n_bad++; $display("FAIL rw_write_wins got=%b want=0", waitrequest); end
    tick();
    write = 1'b0;
    exp_q.push_back(32'hC0FFEE00);
    do_read(32'h308, d, lat);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL rw_data got=%08h want=%08h", d, e); end
    n_cmp++; if (lat !== cur_w + 2) begin n_bad++; $display("FAIL rw_latency got=%0d want=%0d", lat, cur_w + 2); end
  endtask

  task automatic test_timer();
    logic [31:0] d, e;
    int lat, first_k;
    set_wait(1);
    do_write(RB + 32'h00, 32'd1000, 4'hF);
    exp_q.push_back(32'd1000 + 32'(cur_w) + 32'd1);
    do_read(RB + 32'h00, d, lat);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL mtime_read got=%0d want=%0d", d, e); end
    do_write(RB + 32'h04, 32'h0, 4'hF);
    do_write(RB + 32'h00, 32'h0, 4'hF);
    do_write(RB + 32'h0C, 32'h0, 4'hF);
    do_write(RB + 32'h08, 32'd50, 4'hF);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_before got=%b want=0", irq); end
    first_k = -1;
    for (int k = 3; k <= 80; k++) begin
      tick();
      if (irq === 1'b1) begin
        first_k = k;
        break;
      end
    end
    n_cmp++; if (first_k !== 51) begin n_bad++; $display("FAIL irq_rise_cycle got=%0d want=51", first_k); end
    do_write(RB + 32'h08, 32'hFFFFFFFF, 4'hF);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_hold got=%b want=1", irq); end
    do_write(RB + 32'h0C, 32'hFFFFFFFF, 4'hF);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_fall got=%b want=0", irq); end
  endtask

  task automatic test_unmapped_drop();
    logic [31:0] d, e;
    int lat, saw_low;
    exp_q.push_back(32'h0);
    do_read(32'h80000000, d, lat);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL unmapped_data got=%08h want=%08h", d, e); end
    n_cmp++; if (lat !== cur_w + 2) begin n_bad++; $display("FAIL unmapped_latency got=%0d want=%0d", lat, cur_w + 2); end
    exp_q.push_back(32'h0);
    do_read(RB + 32'h14, d, lat);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL unmapped_reg got=%08h want=%08h", d, e); end
    set_wait(3);
    address = 32'h100; read = 1'b1;
    tick(); tick();
    n_cmp++; if (waitrequest !== 1'b1) begin n_bad++; $display("FAIL drop_in_wait got=%b want=1", waitrequest); end
    read = 1'b0;
    saw_low = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (waitrequest !== 1'b1) saw_low++;
    end
    n_cmp++; if (saw_low !== 0) begin n_bad++; $display("FAIL drop_no_ack got=%0d low cycles want=0", saw_low); end
    exp_q.push_back(32'hDEADBEEF);
    do_read(32'h100, d, lat);
    e = exp_q.pop_front();
    n_cmp++; if (lat !== cur_w + 2) begin n_bad++; $display("FAIL drop_then_idle got=%0d want=%0d", lat, cur_w + 2); end
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL drop_then_data got=%08h want=%08h", d, e); end
  endtask

  task automatic test_reset_midread();
    logic [31:0] d, e;
    int lat;
    do_write(RB + 32'h0C, 32'h0, 4'hF);
    do_write(RB + 32'h08, 32'h0, 4'hF);
    tick();
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_pre_reset got=%b want=1", irq); end
    set_wait(5);
    address = 32'h100; read = 1'b1;
    tick(); tick();
    nreset = 1'b0;
    #1;
    n_cmp++; if (waitrequest !== 1'b1) begin n_bad++; $display("FAIL midreset_waitreq got=%b want=1", waitrequest); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL midreset_irq got=%b want=0", irq); end
    n_cmp++; if (readdata !== 32'h0) begin n_bad++; $display("FAIL midreset_readdata got=%08h want=00000000", readdata); end
    read = 1'b0;
    tick(); tick();
    nreset = 1'b1;
    cur_w = 1;
    tick();
    exp_q.push_back(32'hDEADBEEF);
    do_read(32'h100, d, lat);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL ram_kept got=%08h want=%08h", d, e); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL post_reset_latency got=%0d want=3", lat); end
  endtask

  initial begin
    test_reset();
    test_ram_rw();
    test_byteenable();
    test_latency();
    test_back_to_back();
    test_timer();
    test_unmapped_drop();
    test_reset_midread();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/riscv_mem_slave.md
RISCV_MEM_SLAVE -- requirements
Module: riscv_mem_slave

Interface
REQ-001 SHALL have parameter MEM_AW, default 12, meaning RAM depth of 2^MEM_AW 32-bit words.
REQ-002 SHALL have parameter REG_BASE, default 32'hAFFFE000, meaning base address of the register region (64 bytes).
REQ-003 SHALL have parameter RESET_WAIT, default 4'd1, meaning the reset value of WAITCFG.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state on rising edge.
REQ-005 SHALL have port nreset, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port address, input, 32, meaning byte address from master.
REQ-007 SHALL have port write, input, 1, meaning write request.
REQ-008 SHALL have port writedata, input, 32, meaning write data.
REQ-009 SHALL have port byteenable, input, 4, meaning per-byte write lane enables.
REQ-010 SHALL have port read, input, 1, meaning read request, held by master until accepted.
REQ-011 SHALL have port readdata, output, 32, meaning read data, valid when read && !waitrequest.
REQ-012 SHALL have port waitrequest, output, 1, meaning stall; low marks transfer completion.
REQ-013 SHALL have port irq, output, 1, meaning timer interrupt to master.

Function
REQ-014 Decode: address < 2^(MEM_AW+2) -> RAM word address[MEM_AW+1:2]; REG_BASE..REG_BASE+0x3F -> registers; else unmapped.
REQ-015 Registers: 0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI, 0x10 WAITCFG (bits 3:0, rest read 0); other offsets unmapped.
REQ-016 Unmapped reads SHALL return 32'h0 with normal read timing; unmapped writes SHALL be ignored.
REQ-017 Writes SHALL be zero-wait: in IDLE with write high, waitrequest low same cycle; data committed at that edge; master may drop write after one cycle.
REQ-018 Write SHALL honour byteenable per lane (RAM and registers); byteenable 4'b0000 is a no-op with completed handshake.
REQ-019 Read FSM states IDLE, WAIT, ACK; IDLE + read (write low) -> WAIT, counter loaded with WAITCFG.
REQ-020 WAIT: counter nonzero -> decrement; counter zero -> ACK, readdata registered at that edge.
REQ-021 ACK: waitrequest low one cycle, readdata held; ACK -> IDLE unconditionally.
REQ-022 Read latency SHALL be WAITCFG+2 cycles from first read cycle to waitrequest low (WAITCFG=0 -> 2).
REQ-023 waitrequest SHALL be high in IDLE without write, in WAIT, and low only per REQ-017/REQ-021.
REQ-024 read and write both high in IDLE: write serviced, read ignored that cycle.
REQ-025 read dropped in WAIT: return to IDLE next edge, no ACK, no side effect.
REQ-026 Write to WAITCFG SHALL affect only reads starting after it.
REQ-027 MTIME (64-bit) SHALL increment by 1 every cycle, wrapping 2^64-1 -> 0; a write to a half replaces that half in that cycle (no increment that cycle).
REQ-028 irq SHALL be registered: high the cycle after MTIME >= MTIMECMP (unsigned 64-bit), low the cycle after it becomes false.
REQ-029 Reads of MTIME halves SHALL return the value at the WAIT->ACK edge; no hi/lo latching.

Reset
REQ-030 nreset low SHALL asynchronously force: FSM IDLE, waitrequest 1, readdata 0, irq 0, MTIME 0, MTIMECMP all ones, WAITCFG RESET_WAIT, counter 0.
REQ-031 Reset mid-read SHALL abort the transfer with no ACK; RAM contents SHALL NOT be reset.

Structure
REQ-032 Package riscv_mem_slave_pkg SHALL hold register offsets, WAITCFG width, FSM state encoding.
REQ-033 Timer (MTIME, MTIMECMP, compare, irq) SHALL be sub-module riscv_mem_timer; RAM and FSM in the top.

Verification
REQ-034 Write 32'hDEADBEEF to 0x100 be=4'hF, then read 0x100 with WAITCFG=1 -> waitrequest low 3rd cycle, readdata 32'hDEADBEEF.
REQ-035 Write 32'h11223344 to 0x200 be=4'b0101 over 0xFFFFFFFF -> read 0xFF22FF44.
REQ-036 Write WAITCFG=5, read 0x0 -> waitrequest low exactly 7 cycles after read asserted; WAITCFG=0 -> 2 cycles.
REQ-037 Write MTIMECMP_HI=0, MTIMECMP_LO=50 after reset -> irq rises when MTIME reaches 50 (+1 cycle); write MTIMECMP_LO=0xFFFFFFFF, MTIMECMP_HI=0xFFFFFFFF -> irq falls.
REQ-038 Read unmapped 0x80000000 -> 32'h0 with WAITCFG+2 latency; drop read mid-WAIT -> no ACK, FSM IDLE.
REQ-039 Assert nreset during WAIT -> waitrequest 1, irq 0 immediately; RAM at 0x100 still 32'hDEADBEEF after release.
